// File: rtl/legv8_fetch_unit.sv
// rtl/legv8_fetch_unit.sv - LEGv8 instruction fetch: PC, imem request, valid/ready word hand-off, branch redirect, halt on zero word
module legv8_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_rvalid,
    output logic [31:0]       instruction,
    output logic [9:0]        opcode,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, PRESENT, HALT} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pc_inc_d;
    logic              req_q;
    logic              valid_q;
    logic              halted_q;
    logic              drop_q;
    logic [31:0]       instr_q;
    logic [9:0]        opcode_q;

    assign pc_inc_d = pc_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            drop_q   <= 1'b0;
            instr_q  <= '0;
            opcode_q <= '0;
        end else begin
            req_q <= 1'b0;
            case (state_q)
                IDLE, HALT: begin
                    if (start) begin
                        state_q  <= REQ;
                        pc_q     <= RESET_PC;
                        addr_q   <= RESET_PC;
                        req_q    <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                REQ: begin
                    state_q <= WAIT;
                    // The request already on the bus can't be recalled, so its response is dropped.
                    if (branch_taken) begin
                        pc_q   <= branch_target;
                        drop_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (branch_taken) begin
                        pc_q <= branch_target;
                        if (imem_rvalid) begin
                            state_q <= REQ;
                            addr_q  <= branch_target;
                            req_q   <= 1'b1;
                            drop_q  <= 1'b0;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= REQ;
                            addr_q  <= pc_q;
                            req_q   <= 1'b1;
                        end else if (imem_rdata == 32'h0) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                            instr_q  <= '0;
                            opcode_q <= '0;
                            valid_q  <= 1'b0;
                        end else begin
                            state_q  <= PRESENT;
                            instr_q  <= imem_rdata;
                            opcode_q <= imem_rdata[31:22];
                            valid_q  <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (branch_taken) begin
                        state_q <= REQ;
                        pc_q    <= branch_target;
                        addr_q  <= branch_target;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end else if (instr_ready) begin
                        state_q <= REQ;
                        pc_q    <= pc_inc_d;
                        addr_q  <= pc_inc_d;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instruction = instr_q;
    assign opcode      = opcode_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// tb/tb_legv8_fetch_unit.sv - self-checking bench for legv8_fetch_unit (8-bit and 4-bit address instances)
module tb_legv8_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       instr_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = '0;

    logic        imem_req_a, imem_rvalid_a = 1'b0, instr_valid_a, halted_a;
    logic [7:0]  imem_addr_a, pc_a;
    logic [31:0] imem_rdata_a = '0, instruction_a;
    logic [9:0]  opcode_a;

    logic        imem_req_b, imem_rvalid_b = 1'b0, instr_valid_b, halted_b;
    logic [3:0]  imem_addr_b, pc_b;
    logic [31:0] imem_rdata_b = '0, instruction_b;
    logic [9:0]  opcode_b;

    logic [31:0] mem [256];
    int mem_lat    = 1;
    int proto_err  = 0;
    int compared   = 0;
    int mismatched = 0;

    legv8_fetch_unit #(.ADDR_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req_a), .imem_addr(imem_addr_a),
        .imem_rdata(imem_rdata_a), .imem_rvalid(imem_rvalid_a),
        .instruction(instruction_a), .opcode(opcode_a),
        .instr_valid(instr_valid_a), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc_a), .halted(halted_a)
    );

    legv8_fetch_unit #(.ADDR_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_rdata(imem_rdata_b), .imem_rvalid(imem_rvalid_b),
        .instruction(instruction_b), .opcode(opcode_b),
        .instr_valid(instr_valid_b), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_target(branch_target[3:0]),
        .pc(pc_b), .halted(halted_b)
    );

    // Memory models: fixed latency mem_lat, garbage on rdata whenever rvalid is low.
    int         cnt_a = 0;
    logic [7:0] pend_a = '0;
    initial forever begin
        @(posedge clk); #1;
        imem_rvalid_a = 1'b0;
        imem_rdata_a  = $urandom;
        if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0) begin imem_rvalid_a = 1'b1; imem_rdata_a = mem[pend_a]; end
        end
        if (imem_req_a) begin
            if (cnt_a > 0) proto_err++;
            cnt_a = mem_lat; pend_a = imem_addr_a;
        end
    end

    int         cnt_b = 0;
    logic [3:0] pend_b = '0;
    initial forever begin
        @(posedge clk); #1;
        imem_rvalid_b = 1'b0;
        imem_rdata_b  = $urandom;
        if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) begin imem_rvalid_b = 1'b1; imem_rdata_b = mem[{4'h0, pend_b}]; end
        end
        if (imem_req_b) begin
            if (cnt_b > 0) proto_err++;
            cnt_b = mem_lat; pend_b = imem_addr_b;
        end
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
        repeat (6) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 30; i++) begin
            if (instr_valid_a) return;
            cycle();
        end
        compared++; mismatched++;
        $display("FAIL %s_timeout: instr_valid=%b required 1", name, instr_valid_a);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cycle();
        compared++; if (imem_req_a !== 1'b0) begin mismatched++; $display("FAIL reset_req: got %b required 0", imem_req_a); end
        compared++; if (imem_addr_a !== 8'h0) begin mismatched++; $display("FAIL reset_addr: got %h required 00", imem_addr_a); end
        compared++; if (instruction_a !== 32'h0 || opcode_a !== 10'h0) begin mismatched++; $display("FAIL reset_instr: got %h/%h required 0/0", instruction_a, opcode_a); end
        compared++; if (instr_valid_a !== 1'b0 || halted_a !== 1'b0) begin mismatched++; $display("FAIL reset_flags: valid=%b halted=%b required 0/0", instr_valid_a, halted_a); end
        compared++; if (pc_a !== 8'h0) begin mismatched++; $display("FAIL reset_pc: got %h required 00", pc_a); end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        mem[0] = 32'h8A00_0041; mem_lat = 1; instr_ready = 1'b1;
        pulse_start();
        compared++; if (imem_req_a !== 1'b1 || imem_addr_a !== 8'h00) begin mismatched++; $display("FAIL basic_req: req=%b addr=%h required 1/00", imem_req_a, imem_addr_a); end
        cycle();
        compared++; if (instr_valid_a !== 1'b0) begin mismatched++; $display("FAIL basic_early_valid: got %b required 0", instr_valid_a); end
        cycle();
        compared++; if (instr_valid_a !== 1'b1 || opcode_a !== 10'h228 || instruction_a !== 32'h8A00_0041) begin
            mismatched++; $display("FAIL basic_word: valid=%b op=%h instr=%h required 1/228/8a000041", instr_valid_a, opcode_a, instruction_a); end
        cycle();
        compared++; if (pc_a !== 8'h01 || imem_req_a !== 1'b1 || imem_addr_a !== 8'h01) begin
            mismatched++; $display("FAIL basic_advance: pc=%h req=%b addr=%h required 01/1/01", pc_a, imem_req_a, imem_addr_a); end
    endtask

    task automatic test_stall();
        int bad = 0;
        do_reset();
        mem_lat = 2; instr_ready = 1'b0;
        pulse_start();
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            if (instruction_a !== mem[0] || opcode_a !== mem[0][31:22] || instr_valid_a !== 1'b1 || imem_req_a !== 1'b0) bad++;
            cycle();
        end
        compared++; if (bad != 0) begin mismatched++; $display("FAIL stall_hold: %0d unstable cycles required 0", bad); end
        instr_ready = 1'b1; cycle();
        compared++; if (pc_a !== 8'h01 || imem_req_a !== 1'b1 || imem_addr_a !== 8'h01) begin
            mismatched++; $display("FAIL stall_release: pc=%h req=%b addr=%h required 01/1/01", pc_a, imem_req_a, imem_addr_a); end
    endtask

    task automatic test_branch_wait();
        bit got = 0;
        bit addr_ok = 1;
        do_reset();
        mem[8'h40] = mem[0] ^ 32'h0F00_0000;
        mem_lat = 3; instr_ready = 1'b0;
        pulse_start();
        cycle();
        branch_taken = 1'b1; branch_target = 8'h40; cycle(); branch_taken = 1'b0;
        compared++; if (pc_a !== 8'h40) begin mismatched++; $display("FAIL brwait_pc: got %h required 40", pc_a); end
        for (int i = 0; i < 20 && !got; i++) begin
            if (imem_req_a && imem_addr_a !== 8'h40) addr_ok = 0;
            if (instr_valid_a) got = 1; else cycle();
        end
        compared++; if (!addr_ok) begin mismatched++; $display("FAIL brwait_addr: request issued to address other than 40"); end
        compared++; if (!got || instruction_a !== mem[8'h40] || pc_a !== 8'h40) begin
            mismatched++; $display("FAIL brwait_word: valid=%b instr=%h pc=%h required 1/%h/40", got, instruction_a, pc_a, mem[8'h40]); end
    endtask

    task automatic test_branch_accept();
        do_reset();
        mem_lat = 1; instr_ready = 1'b1;
        pulse_start();
        wait_valid("bracc");
        branch_taken = 1'b1; branch_target = 8'h10; cycle(); branch_taken = 1'b0;
        compared++; if (pc_a !== 8'h10 || imem_req_a !== 1'b1 || imem_addr_a !== 8'h10 || instr_valid_a !== 1'b0) begin
            mismatched++; $display("FAIL bracc_redirect: pc=%h req=%b addr=%h valid=%b required 10/1/10/0", pc_a, imem_req_a, imem_addr_a, instr_valid_a); end
        wait_valid("bracc2");
        compared++; if (instruction_a !== mem[8'h10]) begin mismatched++; $display("FAIL bracc_word: got %h required %h", instruction_a, mem[8'h10]); end
    endtask

    task automatic test_halt();
        int words = 0;
        int bad = 0;
        logic [31:0] saved;
        do_reset();
        saved = mem[2]; mem[2] = 32'h0; mem_lat = 1; instr_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 40 && !halted_a; i++) begin
            if (instr_valid_a) words++;
            cycle();
        end
        compared++; if (halted_a !== 1'b1 || instr_valid_a !== 1'b0 || words != 2) begin
            mismatched++; $display("FAIL halt_enter: halted=%b valid=%b words=%0d required 1/0/2", halted_a, instr_valid_a, words); end
        branch_taken = 1'b1; branch_target = 8'h33;
        for (int i = 0; i < 5; i++) begin
            if (imem_req_a !== 1'b0 || halted_a !== 1'b1) bad++;
            cycle();
        end
        branch_taken = 1'b0;
        compared++; if (bad != 0) begin mismatched++; $display("FAIL halt_quiet: %0d active cycles required 0", bad); end
        pulse_start();
        compared++; if (imem_req_a !== 1'b1 || imem_addr_a !== 8'h00 || halted_a !== 1'b0 || pc_a !== 8'h00) begin
            mismatched++; $display("FAIL halt_restart: req=%b addr=%h halted=%b pc=%h required 1/00/0/00", imem_req_a, imem_addr_a, halted_a, pc_a); end
        mem[2] = saved;
    endtask

    task automatic test_wrap();
        bit got = 0;
        do_reset();
        mem_lat = 1; instr_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 30 && !instr_valid_b; i++) cycle();
        branch_taken = 1'b1; branch_target = 8'h0F; cycle(); branch_taken = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            if (instr_valid_b) got = 1; else cycle();
        end
        compared++; if (!got || pc_b !== 4'hF || instruction_b !== mem[15]) begin
            mismatched++; $display("FAIL wrap_word: valid=%b pc=%h instr=%h required 1/f/%h", got, pc_b, instruction_b, mem[15]); end
        cycle();
        compared++; if (imem_req_b !== 1'b1 || imem_addr_b !== 4'h0 || pc_b !== 4'h0) begin
            mismatched++; $display("FAIL wrap_next: req=%b addr=%h pc=%h required 1/0/0", imem_req_b, imem_addr_b, pc_b); end
    endtask

    task automatic test_reset_wait();
        int bad = 0;
        do_reset();
        mem_lat = 4;
        pulse_start();
        cycle();
        rst_n = 1'b0; #1;
        compared++; if (imem_req_a !== 1'b0 || instr_valid_a !== 1'b0 || pc_a !== 8'h0 || halted_a !== 1'b0 || imem_addr_a !== 8'h0 || instruction_a !== 32'h0) begin
            mismatched++; $display("FAIL rstwait_async: req=%b valid=%b pc=%h halted=%b addr=%h instr=%h required all 0", imem_req_a, instr_valid_a, pc_a, halted_a, imem_addr_a, instruction_a); end
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (instr_valid_a !== 1'b0 || imem_req_a !== 1'b0) bad++;
            cycle();
        end
        compared++; if (bad != 0) begin mismatched++; $display("FAIL rstwait_stale: %0d active cycles required 0", bad); end
    endtask

    task automatic test_random(input int lat);
        logic [7:0] exp_pc;
        int accepted = 0;
        do_reset();
        mem_lat = lat;
        pulse_start();
        exp_pc = 8'h00;
        for (int c = 0; c < 500; c++) begin
            if (imem_req_a) begin
                compared++;
                if (imem_addr_a !== exp_pc) begin mismatched++; $display("FAIL rand_addr c=%0d: got %h required %h", c, imem_addr_a, exp_pc); end
            end
            if (instr_valid_a) begin
                compared++;
                if (instruction_a !== mem[exp_pc] || opcode_a !== mem[exp_pc][31:22] || pc_a !== exp_pc) begin
                    mismatched++; $display("FAIL rand_word c=%0d: instr=%h pc=%h required %h/%h", c, instruction_a, pc_a, mem[exp_pc], exp_pc); end
            end
            instr_ready   = 1'($urandom_range(0, 1));
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = 8'($urandom);
            if (branch_taken) exp_pc = branch_target;
            else if (instr_valid_a && instr_ready) begin exp_pc = exp_pc + 8'd1; accepted++; end
            cycle();
        end
        branch_taken = 1'b0;
        compared++; if (halted_a !== 1'b0 || accepted == 0) begin mismatched++; $display("FAIL rand_progress: halted=%b accepted=%0d required 0/>0", halted_a, accepted); end
        compared++; if (proto_err != 0) begin mismatched++; $display("FAIL rand_outstanding: %0d overlapping requests required 0", proto_err); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h0000_0100;
        test_reset();
        test_basic();
        test_stall();
        test_branch_wait();
        test_branch_accept();
        test_halt();
        test_wrap();
        test_reset_wait();
        test_random(1);
        test_random($urandom_range(2, 4));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/legv8_fetch_unit.md
Name: legv8_fetch_unit

Overview:
- Instruction-supply end of the controller interface: owns the program counter, reads instruction memory, and presents one instruction word plus its decoded opcode field to the FSM controller under a valid/ready handshake.
- Handles branch redirects from the controller and halts on an all-zero instruction word, which is the controller's idle encoding.
- Sits between the instruction memory and the controller; one memory request is outstanding at a time.

Parameters:
- ADDR_W, 8, instruction memory word-address width; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded at reset and on restart.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE/HALT and begins fetching at RESET_PC.
- imem_req  out  1  one-cycle read request strobe.
- imem_addr  out  ADDR_W  word address, valid while imem_req=1.
- imem_rdata  in  32  read data, sampled when imem_rvalid=1.
- imem_rvalid  in  1  read response strobe, latency ≥1 cycle after imem_req.
- instruction  out  32  instruction word to controller.
- opcode  out  10  instruction[31:22].
- instr_valid  out  1  instruction/opcode hold a live word.
- instr_ready  in  1  controller accepts the current word.
- branch_taken  in  1  redirect request.
- branch_target  in  ADDR_W  redirect word address.
- pc  out  ADDR_W  address of the word in, or headed to, the instruction register.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, pc=RESET_PC, instruction=0, opcode=0, instr_valid=0, imem_req=0, imem_addr=0, halted=0, drop flag=0.
- States: IDLE, REQ, WAIT, PRESENT, HALT.
- IDLE: outputs quiet. start -> REQ with pc=RESET_PC.
- REQ: imem_req=1 and imem_addr=pc for exactly one cycle -> WAIT.
- WAIT: on imem_rvalid, decide in this order:
  - drop flag set: discard the data, clear the flag -> REQ.
  - rdata==0: instruction=0, opcode=0, instr_valid=0 -> HALT.
  - otherwise: register instruction=rdata and opcode=rdata[31:22], set instr_valid=1 -> PRESENT.
- PRESENT: instruction/opcode are held stable while instr_valid=1 and instr_ready=0. Accept (valid&ready) -> instr_valid=0, pc=pc+1 (wraps to 0 at 2^ADDR_W-1) -> REQ. Issue-to-valid latency is 1 + memory latency cycles; back-to-back accepted words are spaced by at least 3 cycles.
- HALT: halted=1, no requests issued. start -> pc=RESET_PC -> REQ with halted cleared. branch_taken is ignored in HALT.
- Branch (branch_taken=1, any state except IDLE/HALT):
  - pc=branch_target; instr_valid cleared the next cycle.
  - In WAIT before the response arrives: set the drop flag and stay in WAIT.
  - In WAIT with imem_rvalid in the same cycle: discard that data -> REQ.
  - In REQ: the issued request is marked for drop -> WAIT.
  - In PRESENT: -> REQ.
  - Branch and accept in the same cycle: branch wins; pc=branch_target, not pc+1.
- start outside IDLE/HALT: ignored.
- An imem_rvalid arriving in IDLE, REQ, PRESENT or HALT is ignored.
- Reset mid-WAIT: all state is cleared. A stale response arriving after reset, while in IDLE, is ignored.
- Never more than one outstanding imem request.

Test Plan:
- Reset then start, memory latency 1, mem[0]=0x8A000041, instr_ready=1 -> imem_req at addr 0; instr_valid 2 cycles later with opcode=0x228; pc advances to 1.
- instr_ready held 0 for 5 cycles with a word presented -> instruction/opcode stable, instr_valid stays 1, no new imem_req; on release pc+1 and the next request is issued.
- Branch to 0x40 while in WAIT, memory latency 3 -> in-flight data discarded and never presented; next imem_addr=0x40; the presented word is mem[0x40].
- Branch and accept in the same cycle, target 0x10 -> pc=0x10, not pc+1; next imem_addr=0x10.
- mem[2]=0 -> after words 0 and 1, HALT with halted=1, instr_valid=0, no further imem_req; start -> fetch resumes at RESET_PC.
- ADDR_W=4 with pc=15 accepted -> next imem_addr=0. Separately, assert rst_n=0 in WAIT -> all outputs return to reset values immediately; a late rvalid causes no instr_valid.
